// File: rtl/venus_soc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : venus_soc_pkg
//  Description : Shared types for the venus_soc memory subsystem: the
//                axi2mem request/response link and the SRAM model states.
//  Revision    : 1.0 - initial release
// ============================================================================
package venus_soc_pkg;

    localparam int AXI2MEM_DATA_WIDTH = 32;
    localparam int AXI2MEM_ADDR_WIDTH = 16;
    localparam int AXI2MEM_STRB_WIDTH = AXI2MEM_DATA_WIDTH / 8;

    // Deepest read pipeline the SRAM model supports.
    localparam int MEM_MAX_RD_LAT = 4;

    typedef struct packed {
        logic                          mem_wr_en;
        logic [AXI2MEM_STRB_WIDTH-1:0] mem_wstrb;
        logic [AXI2MEM_ADDR_WIDTH-1:0] mem_waddr;
        logic [AXI2MEM_DATA_WIDTH-1:0] mem_wdata;
        logic                          mem_rd_en;
        logic [AXI2MEM_ADDR_WIDTH-1:0] mem_raddr;
    } axi2mem_req_t;

    typedef struct packed {
        logic [AXI2MEM_DATA_WIDTH-1:0] mem_rdata;
    } axi2mem_resp_t;

    typedef enum logic [0:0] {
        MEM_CLEAR = 1'b0,
        MEM_READY = 1'b1
    } mem_state_e;

endpackage : venus_soc_pkg
`default_nettype wire

// File: rtl/axi_mem_rd_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : axi_mem_rd_pipe
//  Description : Fixed-latency read return pipe. A {valid,data} shift register
//                whose last data stage only loads on a valid entry, so it also
//                acts as the hold register for the returned read data.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_mem_rd_pipe
    import venus_soc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data
);

    // Out-of-range latencies are clamped into the supported 1..MEM_MAX_RD_LAT window.
    localparam int c_LAT = (LATENCY > MEM_MAX_RD_LAT) ? MEM_MAX_RD_LAT :
                           ((LATENCY < 1) ? 1 : LATENCY);

    logic [c_LAT-1:0]                 r_vld;
    logic [c_LAT-1:0][DATA_WIDTH-1:0] r_dat;

    // Shift valid every cycle; move data only with a valid entry so the tail holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            r_dat <= '0;
        end else begin
            r_vld[0] <= i_valid;
            if (i_valid) begin
                r_dat[0] <= i_data;
            end
            for (int i = 1; i < c_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                if (r_vld[i-1]) begin
                    r_dat[i] <= r_dat[i-1];
                end
            end
        end
    end

    assign o_valid = r_vld[c_LAT-1];
    assign o_data  = r_dat[c_LAT-1];

endmodule : axi_mem_rd_pipe
`default_nettype wire

// File: rtl/axi_mem_sram_model.sv
`default_nettype none
// ============================================================================
//  Module      : axi_mem_sram_model
//  Description : Word-addressed byte-strobed SRAM behind the axi2mem link,
//                with a configurable read latency, selectable read-during-
//                write behaviour and a post-reset clear sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_mem_sram_model
    import venus_soc_pkg::*;
#(
    parameter int                    DATA_WIDTH    = AXI2MEM_DATA_WIDTH,
    parameter int                    ADDR_WIDTH    = AXI2MEM_ADDR_WIDTH,
    parameter int                    STRB_WIDTH    = DATA_WIDTH / 8,
    parameter int                    WORD_AW       = ADDR_WIDTH - $clog2(STRB_WIDTH),
    parameter int                    DEPTH         = 2 ** WORD_AW,
    parameter int                    READ_LATENCY  = 1,
    parameter bit                    RDW_NEW       = 1'b0,
    parameter bit                    INIT_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  axi2mem_req_t  axi2mem_req_i,
    output axi2mem_resp_t axi2mem_resp_o,
    output logic          rd_valid_o,
    output logic          init_done_o,
    output logic          init_drop_o
);

    localparam int c_OFF = $clog2(STRB_WIDTH);

    mem_state_e            r_state;
    logic [WORD_AW-1:0]    r_clr_cnt;
    logic                  r_init_done;
    logic                  r_init_drop;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [WORD_AW-1:0]    w_widx;
    logic [WORD_AW-1:0]    w_ridx;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_port_we;
    logic [STRB_WIDTH-1:0] w_port_be;
    logic [DATA_WIDTH-1:0] w_port_wd;
    logic [WORD_AW-1:0]    w_port_idx;
    logic [DATA_WIDTH-1:0] w_rword;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_unused;

    // Byte-offset bits (and any address bits above ADDR_WIDTH) do not select a word.
    assign w_widx   = axi2mem_req_i.mem_waddr[ADDR_WIDTH-1:c_OFF];
    assign w_ridx   = axi2mem_req_i.mem_raddr[ADDR_WIDTH-1:c_OFF];
    assign w_unused = ^{axi2mem_req_i.mem_waddr, axi2mem_req_i.mem_raddr};

    // Traffic is only served once init_done_o is visible to the requester.
    assign w_wr_acc = r_init_done & ~rst & axi2mem_req_i.mem_wr_en;
    assign w_rd_acc = r_init_done & ~rst & axi2mem_req_i.mem_rd_en;

    // Single write port shared between the clear sequencer and requests.
    always_comb begin
        w_port_we  = w_wr_acc;
        w_port_be  = axi2mem_req_i.mem_wstrb;
        w_port_wd  = axi2mem_req_i.mem_wdata[DATA_WIDTH-1:0];
        w_port_idx = w_widx;
        if (r_state == MEM_CLEAR) begin
            w_port_we  = ~rst;
            w_port_be  = '1;
            w_port_wd  = INIT_VALUE;
            w_port_idx = r_clr_cnt;
        end
    end

    // Byte-enable storage: each lane written independently under its strobe.
    always_ff @(posedge clk) begin
        if (w_port_we) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (w_port_be[b]) begin
                    r_mem[w_port_idx][8*b +: 8] <= w_port_wd[8*b +: 8];
                end
            end
        end
    end

    // Read word; with RDW_NEW a same-cycle write to the same word is forwarded lane by lane.
    always_comb begin
        w_rword = r_mem[w_ridx];
        if (RDW_NEW && w_wr_acc && (w_widx == w_ridx)) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (axi2mem_req_i.mem_wstrb[b]) begin
                    w_rword[8*b +: 8] = axi2mem_req_i.mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // Clear sequencer, init-done flag and sticky drop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= INIT_ON_RESET ? MEM_CLEAR : MEM_READY;
            r_clr_cnt   <= '0;
            r_init_done <= ~INIT_ON_RESET;
            r_init_drop <= 1'b0;
        end else begin
            r_init_done <= (r_state == MEM_READY);
            if (r_state == MEM_CLEAR) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
                if (r_clr_cnt == WORD_AW'(DEPTH - 1)) begin
                    r_state <= MEM_READY;
                end
            end
            if (!r_init_done && (axi2mem_req_i.mem_wr_en || axi2mem_req_i.mem_rd_en)) begin
                r_init_drop <= 1'b1;
            end
        end
    end

    axi_mem_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (READ_LATENCY)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_rd_acc),
        .i_data  (w_rword),
        .o_valid (rd_valid_o),
        .o_data  (w_rdata)
    );

    assign axi2mem_resp_o.mem_rdata = w_rdata;
    assign init_done_o              = r_init_done;
    assign init_drop_o              = r_init_drop;

endmodule : axi_mem_sram_model
`default_nettype wire

// File: tb/tb_axi_mem_sram_model.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_mem_sram_model
//  Description : Scoreboard bench for axi_mem_sram_model. Two instances share
//                one request stream: A (latency 3, old-data RDW) and
//                B (latency 2, merged-data RDW), both 16 words deep.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_mem_sram_model;
    import venus_soc_pkg::*;

    localparam int          c_DEPTH = 16;
    localparam int          c_LAT_A = 3;
    localparam int          c_LAT_B = 2;
    localparam logic [31:0] c_INIT_A = 32'hC0FF_EE00;
    localparam logic [31:0] c_INIT_B = 32'h5A5A_A5A5;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    axi2mem_req_t  req;
    axi2mem_resp_t resp_a, resp_b;
    logic          rd_valid_a, rd_valid_b;
    logic          init_done_a, init_done_b;
    logic          init_drop_a, init_drop_b;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [31:0] mem_a [c_DEPTH];
    logic [31:0] mem_b [c_DEPTH];
    exp_t        q_a [$];
    exp_t        q_b [$];
    logic [31:0] last_a = '0;
    logic [31:0] last_b = '0;
    logic        model_ready = 1'b0;
    logic        drop_exp    = 1'b0;

    axi_mem_sram_model #(
        .ADDR_WIDTH(6), .READ_LATENCY(c_LAT_A), .RDW_NEW(1'b0),
        .INIT_ON_RESET(1'b1), .INIT_VALUE(c_INIT_A)
    ) dut_a (
        .clk(clk), .rst(rst), .axi2mem_req_i(req), .axi2mem_resp_o(resp_a),
        .rd_valid_o(rd_valid_a), .init_done_o(init_done_a), .init_drop_o(init_drop_a)
    );

    axi_mem_sram_model #(
        .ADDR_WIDTH(6), .READ_LATENCY(c_LAT_B), .RDW_NEW(1'b1),
        .INIT_ON_RESET(1'b1), .INIT_VALUE(c_INIT_B)
    ) dut_b (
        .clk(clk), .rst(rst), .axi2mem_req_i(req), .axi2mem_resp_o(resp_b),
        .rd_valid_o(rd_valid_b), .init_done_o(init_done_b), .init_drop_o(init_drop_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old_w & ~m) | (new_w & m);
    endfunction

    // Issue one request cycle and record what the memory should do with it.
    task automatic drive(input logic wr, input logic [3:0] strb, input logic [15:0] waddr,
                         input logic [31:0] wdata, input logic rd, input logic [15:0] raddr);
        int   wi;
        int   ri;
        exp_t e;
        @(negedge clk);
        req.mem_wr_en = wr;
        req.mem_wstrb = strb;
        req.mem_waddr = waddr;
        req.mem_wdata = wdata;
        req.mem_rd_en = rd;
        req.mem_raddr = raddr;
        wi = (int'(waddr) / 4) % c_DEPTH;
        ri = (int'(raddr) / 4) % c_DEPTH;
        if (model_ready) begin
            if (rd) begin
                e.due  = cyc + c_LAT_A;
                e.data = mem_a[ri];
                q_a.push_back(e);
                e.due  = cyc + c_LAT_B;
                e.data = (wr && wi == ri) ? merge(mem_b[ri], wdata, strb) : mem_b[ri];
                q_b.push_back(e);
            end
            if (wr) begin
                mem_a[wi] = merge(mem_a[wi], wdata, strb);
                mem_b[wi] = merge(mem_b[wi], wdata, strb);
            end
        end else if (wr || rd) begin
            drop_exp = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 16'h0, 32'h0, 1'b0, 16'h0);
    endtask

    task automatic rd_word(input int w);
        drive(1'b0, 4'h0, 16'h0, 32'h0, 1'b1, 16'(w * 4));
    endtask

    // Reset, then follow the clear; optionally inject a request or abort part way.
    task automatic do_reset(input int drop_cycle, input int abort_at);
        int ka;
        int kb;
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        q_a.delete();
        q_b.delete();
        last_a      = '0;
        last_b      = '0;
        model_ready = 1'b0;
        drop_exp    = 1'b0;
        @(posedge clk); #1;
        chk("rst_rd_valid_a", 32'(rd_valid_a), 32'h0);
        chk("rst_rd_valid_b", 32'(rd_valid_b), 32'h0);
        chk("rst_init_done_a", 32'(init_done_a), 32'h0);
        chk("rst_init_drop_b", 32'(init_drop_b), 32'h0);
        chk("rst_rdata_a", resp_a.mem_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < c_DEPTH; i++) begin
            mem_a[i] = c_INIT_A;
            mem_b[i] = c_INIT_B;
        end
        ka = 0;
        kb = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k == abort_at) return;
            if (init_done_a && ka == 0) ka = k;
            if (init_done_b && kb == 0) kb = k;
            if (ka != 0 && kb != 0) break;
            if (k == drop_cycle) drive(1'b0, 4'h0, 16'h0, 32'h0, 1'b1, 16'h0008);
            else if (k == drop_cycle + 1) idle(1);
        end
        chk("init_done_latency_a", 32'(ka), 32'd17);
        chk("init_done_latency_b", 32'(kb), 32'd17);
        chk("init_drop_a", 32'(init_drop_a), 32'(drop_exp));
        chk("init_drop_b", 32'(init_drop_b), 32'(drop_exp));
        model_ready = 1'b1;
    endtask

    // Scoreboard monitor: timing and data of every returned read, hold value otherwise.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rd_valid_a) begin
            if (q_a.size() == 0) chk("unexpected_rd_valid_a", 32'(rd_valid_a), 32'h0);
            else begin
                e = q_a.pop_front();
                chk("rdata_a", resp_a.mem_rdata, e.data);
                chk("rd_latency_a", 32'(cyc), 32'(e.due));
                last_a = e.data;
            end
        end else begin
            if (q_a.size() != 0 && q_a[0].due <= cyc) begin
                e = q_a.pop_front();
                chk("missing_rd_valid_a", 32'(rd_valid_a), 32'h1);
            end
            chk("hold_rdata_a", resp_a.mem_rdata, last_a);
        end
        if (rd_valid_b) begin
            if (q_b.size() == 0) chk("unexpected_rd_valid_b", 32'(rd_valid_b), 32'h0);
            else begin
                e = q_b.pop_front();
                chk("rdata_b", resp_b.mem_rdata, e.data);
                chk("rd_latency_b", 32'(cyc), 32'(e.due));
                last_b = e.data;
            end
        end else begin
            if (q_b.size() != 0 && q_b[0].due <= cyc) begin
                e = q_b.pop_front();
                chk("missing_rd_valid_b", 32'(rd_valid_b), 32'h1);
            end
            chk("hold_rdata_b", resp_b.mem_rdata, last_b);
        end
    end

    initial begin
        logic        wr;
        logic        rd;
        logic [3:0]  strb;
        logic [15:0] wa;
        logic [15:0] ra;
        logic [31:0] wd;
        req = '0;
        repeat (2) @(negedge clk);

        // Clear timing and cleared contents
        do_reset(-1, -1);
        rd_word(0);
        rd_word(15);
        rd_word(int'($urandom_range(1, 14)));
        idle(2);

        // Strobed write merge
        drive(1'b1, 4'hF, 16'h0010, 32'hDEAD_BEEF, 1'b0, 16'h0);
        drive(1'b1, 4'h1, 16'h0012, 32'h0000_00AA, 1'b0, 16'h0);
        rd_word(4);
        idle(2);

        // Back-to-back reads of words 0..7
        for (int w = 0; w < 8; w++) rd_word(w);
        idle(5);

        // Read-during-write to the same word, then to different words
        drive(1'b1, 4'hF, 16'h0014, 32'h1122_3344, 1'b0, 16'h0);
        drive(1'b1, 4'h3, 16'h0014, 32'hAABB_CCDD, 1'b1, 16'h0014);
        drive(1'b1, 4'hC, 16'h0018, 32'h9988_7766, 1'b1, 16'h0014);
        idle(5);

        // Randomised traffic with frequent address collisions and high address bits set
        for (int n = 0; n < 400; n++) begin
            wr   = 1'($urandom_range(0, 1));
            rd   = 1'($urandom_range(0, 1));
            strb = 4'($urandom);
            wa   = 16'($urandom);
            wd   = $urandom;
            ra   = ($urandom_range(0, 3) == 0) ? wa : 16'($urandom);
            drive(wr, strb, wa, wd, rd, ra);
        end
        idle(6);
        chk("init_drop_after_traffic_a", 32'(init_drop_a), 32'h0);

        // Reset in the middle of a clear, then a clear with a dropped read
        do_reset(-1, 5);
        do_reset(2, -1);
        idle(10);
        chk("init_drop_sticky_a", 32'(init_drop_a), 32'h1);
        chk("init_drop_sticky_b", 32'(init_drop_b), 32'h1);
        rd_word(2);
        idle(4);

        // Reset one cycle after a read is accepted
        drive(1'b1, 4'hF, 16'h0020, 32'h0BAD_F00D, 1'b0, 16'h0);
        rd_word(8);
        do_reset(-1, -1);
        rd_word(8);
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_axi_mem_sram_model
`default_nettype wire
